// File: rtl/fp_decode_stage_if.sv
// Handshake and control bundle signals between fetch/issue, the FP decode
// stage and the FP execution unit. The slave view belongs to the decode
// stage; the master view belongs to whatever drives and consumes it.
interface fp_decode_stage_if;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [31:0] instr_i;
   logic [2:0]  frm_i;
   logic        dec_valid_o;
   logic        dec_ready_i;
   logic [3:0]  fp_alu_operator_o;
   logic        fp_alu_op_mod_o;
   logic [2:0]  fp_src_fmt_o;
   logic [2:0]  fp_dst_fmt_o;
   logic [2:0]  fp_rounding_mode_o;
   logic [4:0]  fp_rf_raddr_a_o;
   logic [4:0]  fp_rf_raddr_b_o;
   logic [4:0]  fp_rf_raddr_c_o;
   logic [4:0]  fp_rf_waddr_o;
   logic        fp_regwrite_o;
   logic        int_reg_write_o;
   logic        fp_load_o;
   logic        fp_store_o;
   logic [11:0] offset_o;
   logic        illegal_insn_o;
   logic        move_en_o;
   logic        load_done_i;
   logic [4:0]  load_done_addr_i;
   logic [31:0] load_busy_o;

   modport slave (
      input  instr_valid_i, instr_i, frm_i, dec_ready_i, load_done_i, load_done_addr_i,
      output instr_ready_o, dec_valid_o, fp_alu_operator_o, fp_alu_op_mod_o,
             fp_src_fmt_o, fp_dst_fmt_o, fp_rounding_mode_o, fp_rf_raddr_a_o,
             fp_rf_raddr_b_o, fp_rf_raddr_c_o, fp_rf_waddr_o, fp_regwrite_o,
             int_reg_write_o, fp_load_o, fp_store_o, offset_o, illegal_insn_o,
             move_en_o, load_busy_o
   );

   modport master (
      output instr_valid_i, instr_i, frm_i, dec_ready_i, load_done_i, load_done_addr_i,
      input  instr_ready_o, dec_valid_o, fp_alu_operator_o, fp_alu_op_mod_o,
             fp_src_fmt_o, fp_dst_fmt_o, fp_rounding_mode_o, fp_rf_raddr_a_o,
             fp_rf_raddr_b_o, fp_rf_raddr_c_o, fp_rf_waddr_o, fp_regwrite_o,
             int_reg_write_o, fp_load_o, fp_store_o, offset_o, illegal_insn_o,
             move_en_o, load_busy_o
   );
endinterface

// File: rtl/fp_decode_stage.sv
// Registered RISC-V F/D decode stage feeding an FPnew-style execution unit.
// One instruction per handshake becomes a registered control bundle; a
// pending-load scoreboard stalls consumers of in-flight FP loads, and a small
// counter stretches a hold window for int/FP transfer instructions.
module fp_decode_stage #(
   parameter int FLEN      = 64,
   parameter int MOVE_HOLD = 2
) (
   input logic            clk_i,
   input logic            rst_i,
   fp_decode_stage_if.slave io
);
   // FPnew operation / format / rounding encodings
   localparam logic [3:0] OP_FMADD = 4'd0,  OP_FNMSUB = 4'd1,  OP_ADD = 4'd2,  OP_MUL = 4'd3;
   localparam logic [3:0] OP_DIV   = 4'd4,  OP_SQRT   = 4'd5,  OP_SGNJ = 4'd6, OP_MINMAX = 4'd7;
   localparam logic [3:0] OP_CMP   = 4'd8,  OP_CLASS  = 4'd9,  OP_F2F = 4'd10, OP_F2I = 4'd11;
   localparam logic [3:0] OP_I2F   = 4'd12;
   localparam logic [2:0] FMT_FP32 = 3'd0,  FMT_FP64  = 3'd1;
   localparam logic [3:0] HOLD     = 4'(MOVE_HOLD);

   typedef struct packed {
      logic [3:0]  op;
      logic        op_mod;
      logic [2:0]  src_fmt;
      logic [2:0]  dst_fmt;
      logic [2:0]  rm;
      logic [4:0]  ra, rb, rc, wa;
      logic        fp_we, int_we, load, store;
      logic [11:0] offset;
      logic        illegal;
   } bundle_t;

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  funct5, rs1, rs2, rs3, rd;
   logic [2:0]  funct3, rm_res;
   logic [1:0]  fmt, src_bits;
   logic        fmt_ok, rm_sens, reads_a, reads_b, reads_c, is_move;
   logic        hazard, accept;
   bundle_t     dec, bundle_reg;
   logic        dec_valid_reg;
   logic [31:0] busy_reg, busy_next;
   logic [3:0]  move_cnt_reg;

   assign instr    = io.instr_i;
   assign opcode   = instr[6:0];
   assign rd       = instr[11:7];
   assign funct3   = instr[14:12];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign fmt      = instr[26:25];
   assign rs3      = instr[31:27];
   assign funct5   = instr[31:27];
   assign src_bits = instr[21:20];
   assign fmt_ok   = (fmt == 2'b00) || (fmt == 2'b01 && FLEN == 64);
   assign rm_res   = (funct3 == 3'b111) ? io.frm_i : funct3;

   // Combinational decode of the offered instruction, including which FP sources it reads
   always_comb begin
      dec         = '0;
      dec.op      = OP_FMADD;
      dec.src_fmt = (fmt == 2'b01) ? FMT_FP64 : FMT_FP32;
      dec.dst_fmt = (fmt == 2'b01) ? FMT_FP64 : FMT_FP32;
      dec.rm      = rm_res;
      dec.ra      = rs1;
      dec.rb      = rs2;
      dec.rc      = rs3;
      dec.wa      = rd;
      rm_sens     = 1'b0;
      reads_a     = 1'b0;
      reads_b     = 1'b0;
      reads_c     = 1'b0;
      is_move     = 1'b0;
      case (opcode)
         7'b0000111: begin // FLW / FLD
            dec.load   = 1'b1;
            dec.fp_we  = 1'b1;
            dec.offset = instr[31:20];
            if (funct3 == 3'b010) begin
               dec.src_fmt = FMT_FP32;
               dec.dst_fmt = FMT_FP32;
            end else if (funct3 == 3'b011 && FLEN == 64) begin
               dec.src_fmt = FMT_FP64;
               dec.dst_fmt = FMT_FP64;
            end else dec.illegal = 1'b1;
         end
         7'b0100111: begin // FSW / FSD
            dec.store  = 1'b1;
            dec.offset = {instr[31:25], instr[11:7]};
            reads_b    = 1'b1;
            if (funct3 == 3'b010) begin
               dec.src_fmt = FMT_FP32;
               dec.dst_fmt = FMT_FP32;
            end else if (funct3 == 3'b011 && FLEN == 64) begin
               dec.src_fmt = FMT_FP64;
               dec.dst_fmt = FMT_FP64;
            end else dec.illegal = 1'b1;
         end
         7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin // fused multiply-add family
            dec.op     = opcode[3] ? OP_FNMSUB : OP_FMADD;
            dec.op_mod = opcode[2];
            dec.fp_we  = 1'b1;
            rm_sens    = 1'b1;
            {reads_a, reads_b, reads_c} = 3'b111;
            if (!fmt_ok) dec.illegal = 1'b1;
         end
         7'b1010011: begin // OP-FP
            if (!fmt_ok) dec.illegal = 1'b1;
            case (funct5)
               5'b00000, 5'b00001, 5'b00010, 5'b00011: begin
                  dec.op     = (funct5[1] == 1'b0) ? OP_ADD : (funct5[0] ? OP_DIV : OP_MUL);
                  dec.op_mod = (funct5[1] == 1'b0) && funct5[0];
                  dec.fp_we  = 1'b1;
                  rm_sens    = 1'b1;
                  {reads_a, reads_b} = 2'b11;
               end
               5'b01011: begin
                  dec.op    = OP_SQRT;
                  dec.fp_we = 1'b1;
                  rm_sens   = 1'b1;
                  reads_a   = 1'b1;
                  if (rs2 != 5'd0) dec.illegal = 1'b1;
               end
               5'b00100, 5'b00101, 5'b10100: begin
                  dec.op = (funct5 == 5'b00100) ? OP_SGNJ : (funct5 == 5'b00101) ? OP_MINMAX : OP_CMP;
                  {reads_a, reads_b} = 2'b11;
                  if (funct5 == 5'b10100) begin
                     dec.int_we = 1'b1;
                     is_move    = 1'b1;
                     if (funct3 >= 3'd3) dec.illegal = 1'b1;
                  end else begin
                     dec.fp_we = 1'b1;
                     if (funct3 >= ((funct5 == 5'b00100) ? 3'd3 : 3'd2)) dec.illegal = 1'b1;
                  end
               end
               5'b01000: begin // FCVT between FP formats: source from rs2 field
                  dec.op      = OP_F2F;
                  dec.src_fmt = {1'b0, src_bits};
                  dec.fp_we   = 1'b1;
                  rm_sens     = 1'b1;
                  reads_a     = 1'b1;
                  if (instr[24:22] != 3'd0 || src_bits == fmt ||
                      !(src_bits == 2'b00 || (src_bits == 2'b01 && FLEN == 64)))
                     dec.illegal = 1'b1;
               end
               5'b11000, 5'b11010: begin // FCVT.W[U].fmt / FCVT.fmt.W[U]
                  dec.op     = funct5[1] ? OP_I2F : OP_F2I;
                  dec.op_mod = instr[20];
                  dec.fp_we  = funct5[1];
                  dec.int_we = !funct5[1];
                  reads_a    = !funct5[1];
                  rm_sens    = 1'b1;
                  if (instr[24:21] != 4'd0) dec.illegal = 1'b1;
               end
               5'b11100: begin // FMV.X.W / FCLASS
                  dec.int_we = 1'b1;
                  is_move    = 1'b1;
                  reads_a    = 1'b1;
                  if (funct3 == 3'b000 && rs2 == 5'd0 && fmt == 2'b00) dec.op = OP_SGNJ;
                  else if (funct3 == 3'b001 && rs2 == 5'd0) dec.op = OP_CLASS;
                  else dec.illegal = 1'b1;
               end
               5'b11110: begin // FMV.W.X
                  dec.op    = OP_SGNJ;
                  dec.fp_we = 1'b1;
                  is_move   = 1'b1;
                  if (!(funct3 == 3'b000 && rs2 == 5'd0 && fmt == 2'b00)) dec.illegal = 1'b1;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         default: dec.illegal = 1'b1;
      endcase
      // Reserved rounding modes only matter where rounding happens
      if (rm_sens && rm_res >= 3'd5) dec.illegal = 1'b1;
      if (dec.illegal) begin
         dec.fp_we  = 1'b0;
         dec.int_we = 1'b0;
         dec.load   = 1'b0;
         dec.store  = 1'b0;
         reads_a    = 1'b0;
         reads_b    = 1'b0;
         reads_c    = 1'b0;
         is_move    = 1'b0;
      end
   end

   assign hazard = (reads_a && busy_reg[rs1]) || (reads_b && busy_reg[rs2]) ||
                   (reads_c && busy_reg[rs3]);
   assign io.instr_ready_o = (!dec_valid_reg || io.dec_ready_i) && !hazard;
   assign accept = io.instr_valid_i && io.instr_ready_o;

   // Output bundle register: loads on accept, held while the consumer stalls
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bundle_reg    <= '0;
         dec_valid_reg <= 1'b0;
      end else begin
         if (accept) bundle_reg <= dec;
         if (accept) dec_valid_reg <= 1'b1;
         else if (io.dec_ready_i) dec_valid_reg <= 1'b0;
      end
   end

   // Scoreboard next state: clear on load completion, set on accepted load (set wins)
   always_comb begin
      busy_next = busy_reg;
      if (io.load_done_i) busy_next[io.load_done_addr_i] = 1'b0;
      if (accept && dec.load) busy_next[rd] = 1'b1;
   end

   // Scoreboard register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) busy_reg <= '0;
      else       busy_reg <= busy_next;
   end

   // Transfer hold counter: (re)loads on a qualifying accept, otherwise counts down
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                    move_cnt_reg <= '0;
      else if (accept && is_move)   move_cnt_reg <= HOLD;
      else if (move_cnt_reg != '0)  move_cnt_reg <= move_cnt_reg - 4'd1;
   end

   assign io.dec_valid_o        = dec_valid_reg;
   assign io.fp_alu_operator_o  = bundle_reg.op;
   assign io.fp_alu_op_mod_o    = bundle_reg.op_mod;
   assign io.fp_src_fmt_o       = bundle_reg.src_fmt;
   assign io.fp_dst_fmt_o       = bundle_reg.dst_fmt;
   assign io.fp_rounding_mode_o = bundle_reg.rm;
   assign io.fp_rf_raddr_a_o    = bundle_reg.ra;
   assign io.fp_rf_raddr_b_o    = bundle_reg.rb;
   assign io.fp_rf_raddr_c_o    = bundle_reg.rc;
   assign io.fp_rf_waddr_o      = bundle_reg.wa;
   assign io.fp_regwrite_o      = bundle_reg.fp_we;
   assign io.int_reg_write_o    = bundle_reg.int_we;
   assign io.fp_load_o          = bundle_reg.load;
   assign io.fp_store_o         = bundle_reg.store;
   assign io.offset_o           = bundle_reg.offset;
   assign io.illegal_insn_o     = bundle_reg.illegal;
   assign io.move_en_o          = (move_cnt_reg != 4'd0);
   assign io.load_busy_o        = busy_reg;
endmodule

// File: doc/fp_decode_stage.md
Name: fp_decode_stage

Overview:
- Registered RISC-V F/D decode stage between instruction fetch/issue and the FPnew-based FP execution unit.
- Decodes one instruction per accepted handshake into a registered control bundle, with valid/ready on both sides.
- Supports FP32 and, when FLEN=64, FP64 formats.
- Keeps a pending-load scoreboard on FP destination registers and stalls dependent instructions.
- Generates a parametrised-length int/FP transfer hold pulse.

Parameters:
- FLEN, 64: FP register width; 32 makes every FP64 encoding (fmt=01, FLD, FSD) illegal; only 32 and 64 are legal.
- MOVE_HOLD, 2: cycles move_en_o stays high per int/FP transfer instruction; range 1..15.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  instruction accepted this cycle when both valid and ready are high
- instr_i  in  32  instruction word
- frm_i  in  3  fcsr.frm, used when instr rm=111
- dec_valid_o  out  1  decoded bundle valid
- dec_ready_i  in  1  consumer takes bundle
- fp_alu_operator_o  out  4  fpnew_pkg::operation_e
- fp_alu_op_mod_o  out  1  operation modifier
- fp_src_fmt_o, fp_dst_fmt_o  out  3 each  fpnew_pkg::fp_format_e
- fp_rounding_mode_o  out  3  resolved fpnew_pkg::roundmode_e
- fp_rf_raddr_a_o, fp_rf_raddr_b_o, fp_rf_raddr_c_o, fp_rf_waddr_o  out  5 each  rs1, rs2, rs3, rd
- fp_regwrite_o  out  1  FP register write
- int_reg_write_o  out  1  integer register write
- fp_load_o, fp_store_o  out  1 each  load / store
- offset_o  out  12  load or store immediate
- illegal_insn_o  out  1  illegal encoding
- move_en_o  out  1  int/FP transfer hold window
- load_done_i  in  1  load writeback completed
- load_done_addr_i  in  5  FP register the load wrote
- load_busy_o  out  32  pending-load bit per FP register

Behaviour:
- Reset: all registered outputs 0, including dec_valid_o, load_busy_o and move_en_o. fp_alu_operator_o resets to FMADD, formats to FP32, rounding mode to RNE.
- Latency: the bundle appears 1 cycle after acceptance and is held stable while dec_valid_o=1 and dec_ready_i=0.
- instr_ready_o = (!dec_valid_o | dec_ready_i) & !hazard. It is combinational and never depends on instr_valid_i.
- Hazard is true when any source register the decoded instruction actually reads has its load_busy bit set. Reads per class:
  - FMA: rs1, rs2, rs3.
  - 2-operand ops: rs1, rs2.
  - FSQRT, FCVT-from-FP, FMV.X, FCLASS: rs1.
  - Stores: rs2.
- The scoreboard has no bypass: a clear takes effect the cycle after load_done_i.
- On a handshake with dec_ready_i=0 and dec_valid_o=0, the bundle loads. If dec_valid_o=1 and dec_ready_i=1 with no new accept, dec_valid_o falls next cycle.
- Format field instr[26:25]: 00 → FP32, 01 → FP64 (legal only if FLEN=64), 10/11 → illegal.
- Loads and stores: funct3 010 → W, funct3 011 → D.
  - Load offset = instr[31:20].
  - Store offset = {instr[31:25], instr[11:7]}.
- Rounding: rm=111 resolves to frm_i. A resolved value of 101, 110 or 111 is illegal for rounding-sensitive ops: FMA, ADD/SUB/MUL/DIV/SQRT, and conversions.
- Operation mapping:
  - FMADD/FMSUB → FMADD with mod 0/1.
  - FNMSUB/FNMADD → FNMSUB with mod 0/1.
  - FADD/FSUB → ADD with mod 0/1.
  - FMUL → MUL, FDIV → DIV, FSQRT → SQRT (requires rs2=0), FSGNJ* → SGNJ (funct3 < 3), FMIN/FMAX → MINMAX (funct3 < 2), FEQ/FLT/FLE → CMP (funct3 < 3).
  - FCVT.W[U] → F2I with mod = instr[20] and int write.
  - FCVT.S.W[U] → I2F with mod = instr[20] and FP write.
  - FCVT.S.D / FCVT.D.S → F2F, src fmt = instr[21:20], dst fmt = instr[26:25].
  - FMV.X.W and FCLASS → int write. FMV.W.X → FP write.
- Any unlisted or malformed encoding is still accepted with illegal_insn_o=1, and all write/load/store enables are forced to 0.
- Scoreboard update on an accepted legal load: set load_busy[rd]. load_done_i clears load_busy[load_done_addr_i]. A set and a clear of the same address in the same cycle → set wins.
- move_en_o: an accepted FMV.X, FMV.W.X, CMP or FCLASS loads a counter with MOVE_HOLD.
  - move_en_o = (counter != 0), and the counter decrements each cycle.
  - A new qualifying accept while the counter is nonzero reloads it (restart).
- Reset mid-operation drops the held bundle, the scoreboard and the counter immediately.

Test Plan:
- FADD.S x3,x1,x2 with rm=000 offered; dec_ready_i=1 → next cycle dec_valid_o=1, operator ADD, mod 0, fmt FP32, waddr 3, fp_regwrite_o=1.
- FLW f5,12(x1) accepted, then FMUL.S f6,f5,f5 → instr_ready_o=0 until the cycle after load_done_i with addr 5. Same-cycle load_done for f5 plus a new FLD f5 accept → load_busy[5] stays 1.
- dec_ready_i=0 for 3 cycles with the bundle held → outputs stable, instr_ready_o=0. Release → the next instruction is accepted in the same cycle.
- FLEN=32: FADD.D (fmt=01) → illegal_insn_o=1, fp_regwrite_o=0. FLEN=64: same instruction → FP64 ADD, legal.
- rm=111 with frm_i=101 on FDIV.S → illegal_insn_o=1. Same instruction with frm_i=010 → rounding mode RDN, legal.
- MOVE_HOLD=2: FMV.X.W accepted at cycle t → move_en_o high at t+1 and t+2. A second FEQ accepted at t+1 → move_en_o stays high through t+3.
